// File: rtl/robot_step_sequencer.sv
// rtl/robot_step_sequencer.sv - step tick, sensor reads with VGA-priority map port, step/ack handshake; option ROBOT_STEP_COUNT_EN
module robot_step_sequencer #(
    parameter int STEP_DIV    = 2,
    parameter int ROWS        = 10,
    parameter int COLS        = 20,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] robot_row,
    input  logic [5:0] robot_column,
    input  logic [2:0] robot_orientation,
    input  logic       robot_ack,
    output logic       step_en,
    output logic       head_sensor,
    output logic       left_sensor,
    output logic [5:0] mem_row,
    output logic [5:0] mem_col,
    input  logic [1:0] mem_rdata,
    input  logic       vga_req,
    input  logic [5:0] vga_row,
    input  logic [5:0] vga_col,
    output logic       vga_valid,
    output logic [1:0] vga_data,
    output logic       ack_timeout,
`ifdef ROBOT_STEP_COUNT_EN
    output logic [15:0] step_count,
`endif
    output logic       tick_overrun
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic signed [6:0] ROWS_S = 7'(ROWS);
    localparam logic signed [6:0] COLS_S = 7'(COLS);

    typedef enum logic [2:0] {IDLE, RD_HEAD, WT_HEAD, RD_LEFT, WT_LEFT, STEP, WAIT_ACK} state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              tick;
    logic [5:0]        pos_row, pos_col, src_row, src_col;
    logic [2:0]        pos_ori, src_ori;
    logic signed [6:0] base_r, base_c, front_r, front_c, left_r, left_c;
    logic              head_out, left_out, wait_expired;

    function automatic logic off_map(input logic signed [6:0] r, input logic signed [6:0] c);
        return (r < 7'sd1) || (r > ROWS_S) || (c < 7'sd1) || (c > COLS_S);
    endfunction

    assign tick         = (div_cnt == DIV_W'(STEP_DIV - 1));
    assign wait_expired = (wait_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign step_en      = (state == STEP);
    assign vga_data     = vga_valid ? mem_rdata : 2'b00;

    // RD_HEAD looks at the live pose; later states use the copy latched there.
    always_comb begin
        src_row = (state == RD_HEAD) ? robot_row         : pos_row;
        src_col = (state == RD_HEAD) ? robot_column      : pos_col;
        src_ori = (state == RD_HEAD) ? robot_orientation : pos_ori;
        base_r  = $signed({1'b0, src_row});
        base_c  = $signed({1'b0, src_col});
        front_r = base_r;
        front_c = base_c;
        left_r  = base_r;
        left_c  = base_c;
        case (src_ori)
            3'd0: begin front_r = base_r - 7'sd1; left_c = base_c - 7'sd1; end
            3'd1: begin front_r = base_r + 7'sd1; left_c = base_c + 7'sd1; end
            3'd2: begin front_c = base_c + 7'sd1; left_r = base_r - 7'sd1; end
            default: begin front_c = base_c - 7'sd1; left_r = base_r + 7'sd1; end
        endcase
        head_out = off_map(front_r, front_c);
        left_out = off_map(left_r, left_c);
    end

    always_comb begin
        mem_row = 6'd0;
        mem_col = 6'd0;
        if (vga_req) begin
            mem_row = vga_row;
            mem_col = vga_col;
        end else if (state == RD_HEAD && !head_out) begin
            mem_row = front_r[5:0];
            mem_col = front_c[5:0];
        end else if (state == RD_LEFT && !left_out) begin
            mem_row = left_r[5:0];
            mem_col = left_c[5:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (tick) state_next = RD_HEAD;
            RD_HEAD:  if (head_out) state_next = RD_LEFT;
                      else if (!vga_req) state_next = WT_HEAD;
            WT_HEAD:  state_next = RD_LEFT;
            RD_LEFT:  if (left_out) state_next = STEP;
                      else if (!vga_req) state_next = WT_LEFT;
            WT_LEFT:  state_next = STEP;
            STEP:     state_next = WAIT_ACK;
            WAIT_ACK: if (robot_ack || wait_expired) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            wait_cnt     <= '0;
            pos_row      <= 6'd0;
            pos_col      <= 6'd0;
            pos_ori      <= 3'd0;
            head_sensor  <= 1'b0;
            left_sensor  <= 1'b0;
            vga_valid    <= 1'b0;
            ack_timeout  <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            wait_cnt  <= (state == WAIT_ACK) ? wait_cnt + 1'b1 : '0;
            vga_valid <= vga_req;
            if (tick && state != IDLE) tick_overrun <= 1'b1;
            if (state == RD_HEAD) begin
                pos_row <= robot_row;
                pos_col <= robot_column;
                pos_ori <= robot_orientation;
            end
            // Trash (10) is passable; wall (01) and reserved (11) both block.
            if (state == RD_HEAD && head_out) head_sensor <= 1'b1;
            if (state == WT_HEAD)             head_sensor <= mem_rdata[0];
            if (state == RD_LEFT && left_out) left_sensor <= 1'b1;
            if (state == WT_LEFT)             left_sensor <= mem_rdata[0];
            if (state == WAIT_ACK && !robot_ack && wait_expired) ack_timeout <= 1'b1;
        end
    end

`ifdef ROBOT_STEP_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            step_count <= 16'd0;
        else if (state == WAIT_ACK && robot_ack && step_count != 16'hFFFF)
            step_count <= step_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_robot_step_sequencer.sv
// tb/tb_robot_step_sequencer.sv - scoreboard bench for robot_step_sequencer
module tb_robot_step_sequencer;

    localparam int D    = 2;
    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int TO   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] robot_row = 6'd0, robot_column = 6'd0;
    logic [2:0] robot_orientation = 3'd0;
    logic       robot_ack = 1'b0;
    logic       step_en, head_sensor, left_sensor;
    logic [5:0] mem_row, mem_col;
    logic [1:0] mem_rdata = 2'b00;
    logic       vga_req = 1'b0;
    logic [5:0] vga_row = 6'd0, vga_col = 6'd0;
    logic       vga_valid;
    logic [1:0] vga_data;
    logic       ack_timeout, tick_overrun;
`ifdef ROBOT_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    robot_step_sequencer #(.STEP_DIV(D), .ROWS(ROWS), .COLS(COLS), .ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .robot_row(robot_row), .robot_column(robot_column),
        .robot_orientation(robot_orientation), .robot_ack(robot_ack),
        .step_en(step_en), .head_sensor(head_sensor), .left_sensor(left_sensor),
        .mem_row(mem_row), .mem_col(mem_col), .mem_rdata(mem_rdata),
        .vga_req(vga_req), .vga_row(vga_row), .vga_col(vga_col),
        .vga_valid(vga_valid), .vga_data(vga_data),
        .ack_timeout(ack_timeout),
`ifdef ROBOT_STEP_COUNT_EN
        .step_count(step_count),
`endif
        .tick_overrun(tick_overrun)
    );

    always #5 clock = ~clock;

    logic [1:0] map [0:63][0:63];
    always @(posedge clock) mem_rdata <= map[mem_row][mem_col];

    // Cycle index since reset release; the step tick falls on index % D == D-1.
    int cyc = 0;
    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct { logic head; logic left; int cycle; } step_exp_t;
    typedef struct { logic [1:0] data; int cycle; } vga_exp_t;
    step_exp_t step_q[$];
    vga_exp_t  vga_q[$];
    step_exp_t se;
    vga_exp_t  ve;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_from = 0;
    int acked = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic void nbr(input int r, input int c, input int o, input bit front,
                                output bit sens, output bit outm);
        int dr = 0;
        int dc = 0;
        int nr, nc;
        case (o)
            0:       if (front) dr = -1; else dc = -1;
            1:       if (front) dr = 1;  else dc = 1;
            2:       if (front) dc = 1;  else dr = -1;
            default: if (front) dc = -1; else dr = 1;
        endcase
        nr = r + dr;
        nc = c + dc;
        outm = (nr < 1) || (nr > ROWS) || (nc < 1) || (nc > COLS);
        sens = outm ? 1'b1 : (map[nr][nc] == 2'b01 || map[nr][nc] == 2'b11);
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            if (step_en) begin
                if (step_q.size() == 0) fail_now("step_en unexpected");
                else begin
                    se = step_q.pop_front();
                    check("head_sensor", head_sensor, se.head);
                    check("left_sensor", left_sensor, se.left);
                    check("step_en cycle", cyc, se.cycle);
                end
            end
            if (vga_valid) begin
                if (vga_q.size() == 0) fail_now("vga_valid unexpected");
                else begin
                    ve = vga_q.pop_front();
                    check("vga_data", vga_data, ve.data);
                    check("vga_valid cycle", cyc, ve.cycle);
                end
            end
        end
    end

    // mode 0: ack after ack_delay WAIT_ACK cycles; 1: no ack; 2: reset during STEP
    task automatic do_step(input int r, input int c, input int o, input int mode,
                           input bit vga_stall, input int ack_delay, input bit spurious);
        bit hs, ho, ls, lo, found;
        int t, s;
        robot_row = 6'(r);
        robot_column = 6'(c);
        robot_orientation = 3'(o);
        nbr(r, c, o, 1'b1, hs, ho);
        nbr(r, c, o, 1'b0, ls, lo);
        t = idle_from;
        while (t % D != D - 1) t++;
        step_q.push_back('{hs, ls, t + 1 + (ho ? 1 : 2) + (lo ? 1 : 2) + (vga_stall ? 6 : 0)});
        if (spurious) begin
            robot_ack = 1'b1;
            next_cycle();
            robot_ack = 1'b0;
        end
        if (vga_stall) begin
            while (cyc < t + 1) next_cycle();
            for (int k = 0; k < 6; k++) begin
                vga_row = 6'($urandom_range(1, ROWS));
                vga_col = 6'($urandom_range(1, COLS));
                vga_req = 1'b1;
                vga_q.push_back('{map[vga_row][vga_col], cyc + 1});
                next_cycle();
            end
            vga_req = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (step_en) found = 1'b1;
            else next_cycle();
        end
        if (!found) begin
            fail_now("step_en never arrived");
            idle_from = cyc;
            return;
        end
        s = cyc;
        if (mode == 0) begin
            repeat (ack_delay + 1) next_cycle();
            robot_ack = 1'b1;
            next_cycle();
            robot_ack = 1'b0;
            acked++;
            idle_from = s + 2 + ack_delay;
        end else if (mode == 1) begin
            repeat (TO) next_cycle();
            check("ack_timeout before expiry", ack_timeout, 0);
            next_cycle();
            check("ack_timeout after expiry", ack_timeout, 1);
            idle_from = s + TO + 1;
        end else begin
            reset = 1'b0;
            #1;
            check("step_en async drop", step_en, 0);
            check("head_sensor after reset", head_sensor, 0);
            check("ack_timeout after reset", ack_timeout, 0);
            check("tick_overrun after reset", tick_overrun, 0);
`ifdef ROBOT_STEP_COUNT_EN
            check("step_count after reset", step_count, 0);
`endif
            step_q.delete();
            next_cycle();
            next_cycle();
            reset = 1'b1;
            idle_from = 0;
            acked = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                map[r][c] = 2'($urandom_range(0, 3));
        map[0][0]  = 2'b11;
        map[5][11] = 2'b01;
        map[4][10] = 2'b10;

        @(negedge clock);
        check("reset step_en", step_en, 0);
        check("reset head_sensor", head_sensor, 0);
        check("reset left_sensor", left_sensor, 0);
        check("reset mem_row", mem_row, 0);
        check("reset mem_col", mem_col, 0);
        check("reset vga_valid", vga_valid, 0);
        check("reset vga_data", vga_data, 0);
        check("reset ack_timeout", ack_timeout, 0);
        check("reset tick_overrun", tick_overrun, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;

        do_step(5, 10, 2, 0, 1'b0, 1, 1'b0);
        check("tick_overrun after first step", tick_overrun, 1);
        do_step(1, 1, 0, 0, 1'b0, 0, 1'b0);
        do_step(3, 7, 1, 0, 1'b1, 2, 1'b0);
        do_step(6, 6, 3, 1, 1'b0, 0, 1'b0);
        do_step(ROWS, COLS, 1, 0, 1'b0, TO - 1, 1'b1);
        do_step(4, 4, 2, 2, 1'b0, 0, 1'b0);

        for (int n = 0; n < 100; n++)
            do_step($urandom_range(0, ROWS + 1), $urandom_range(0, COLS + 1),
                    $urandom_range(0, 3), 0, 1'b0, $urandom_range(0, TO - 1),
                    $urandom_range(0, 3) == 0);

`ifdef ROBOT_STEP_COUNT_EN
        check("step_count", step_count, acked);
`endif
        repeat (4) next_cycle();
        check("step queue drained", step_q.size(), 0);
        check("vga queue drained", vga_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
